// File: rtl/controller_pkg.sv
// Shared types for the I3C/I2C controller slice.
package controller_pkg;

    typedef enum logic [1:0] {
        BUS_FREE   = 2'd0,
        BUS_ACTIVE = 2'd1,
        BUS_HDR    = 2'd2
    } bus_state_e;

endpackage

// File: rtl/bus_line_filter.sv
// Qualified edge pulses and stable-level flags for one synchronised bus line.
module bus_line_filter #(
    parameter int unsigned CntW = 20
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            enable_i,
    input  logic            line_i,
    input  logic [CntW-1:0] t_r_i,
    input  logic [CntW-1:0] t_f_i,
    output logic            posedge_o,
    output logic            negedge_o,
    output logic            stable_high_o,
    output logic            stable_low_o
);

    localparam logic [CntW-1:0] CntMax = '1;

    logic            prev_q, prev_d;
    logic            rise_pend_q, rise_pend_d;
    logic            fall_pend_q, fall_pend_d;
    logic [CntW-1:0] rise_cnt_q, rise_cnt_d;
    logic [CntW-1:0] fall_cnt_q, fall_cnt_d;
    logic [CntW-1:0] high_cnt_q, high_cnt_d;
    logic [CntW-1:0] low_cnt_q, low_cnt_d;

    always_comb begin
        prev_d      = line_i;
        rise_pend_d = rise_pend_q;
        rise_cnt_d  = rise_cnt_q;
        fall_pend_d = fall_pend_q;
        fall_cnt_d  = fall_cnt_q;

        // A pending edge fires on expiry or is dropped if the line reverts.
        if (rise_pend_q) begin
            if (!line_i || rise_cnt_q == '0) rise_pend_d = 1'b0;
            else                             rise_cnt_d  = rise_cnt_q - 1'b1;
        end
        if (fall_pend_q) begin
            if (line_i || fall_cnt_q == '0) fall_pend_d = 1'b0;
            else                            fall_cnt_d  = fall_cnt_q - 1'b1;
        end

        if (line_i && !prev_q) begin
            rise_pend_d = 1'b1;
            rise_cnt_d  = t_r_i;
        end
        if (!line_i && prev_q) begin
            fall_pend_d = 1'b1;
            fall_cnt_d  = t_f_i;
        end

        high_cnt_d = !line_i ? '0 : (high_cnt_q == CntMax) ? high_cnt_q : high_cnt_q + 1'b1;
        low_cnt_d  = line_i  ? '0 : (low_cnt_q == CntMax)  ? low_cnt_q  : low_cnt_q + 1'b1;

        if (!enable_i) begin
            prev_d      = 1'b1;
            rise_pend_d = 1'b0;
            fall_pend_d = 1'b0;
            rise_cnt_d  = '0;
            fall_cnt_d  = '0;
            high_cnt_d  = '0;
            low_cnt_d   = '0;
        end
    end

    always_comb begin
        posedge_o     = enable_i && rise_pend_q && (rise_cnt_q == '0) && line_i;
        negedge_o     = enable_i && fall_pend_q && (fall_cnt_q == '0) && !line_i;
        stable_high_o = enable_i && line_i && (high_cnt_q != '0) && (high_cnt_q >= t_r_i);
        stable_low_o  = enable_i && !line_i && (low_cnt_q != '0) && (low_cnt_q >= t_f_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q      <= 1'b1;
            rise_pend_q <= 1'b0;
            fall_pend_q <= 1'b0;
            rise_cnt_q  <= '0;
            fall_cnt_q  <= '0;
            high_cnt_q  <= '0;
            low_cnt_q   <= '0;
        end else begin
            prev_q      <= prev_d;
            rise_pend_q <= rise_pend_d;
            fall_pend_q <= fall_pend_d;
            rise_cnt_q  <= rise_cnt_d;
            fall_cnt_q  <= fall_cnt_d;
            high_cnt_q  <= high_cnt_d;
            low_cnt_q   <= low_cnt_d;
        end
    end

endmodule

// File: rtl/bus_event_monitor.sv
// I3C/I2C bus observer: framing events, bus state, idle timing and SDA arbitration loss.
module bus_event_monitor
    import controller_pkg::*;
#(
    parameter int unsigned CntW         = 20,
    parameter int unsigned HdrExitFalls = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            enable_i,
    input  logic            scl_i,
    input  logic            sda_i,
    input  logic            sda_drive_i,
    input  logic            sda_drive_en_i,
    input  logic            is_in_hdr_mode_i,
    input  logic [CntW-1:0] t_r_i,
    input  logic [CntW-1:0] t_f_i,
    input  logic [CntW-1:0] t_avail_i,
    input  logic [CntW-1:0] t_idle_i,
    output logic            scl_negedge_o,
    output logic            scl_posedge_o,
    output logic            sda_negedge_o,
    output logic            sda_posedge_o,
    output logic            scl_stable_high_o,
    output logic            scl_stable_low_o,
    output logic            start_det_o,
    output logic            rstart_det_o,
    output logic            stop_det_o,
    output logic            hdr_exit_det_o,
    output logic            bus_available_o,
    output logic            bus_idle_o,
    output logic            arb_lost_o,
    output logic            arb_lost_sticky_o,
    output bus_state_e      bus_state_o
);

    localparam int unsigned ExitW = $clog2(HdrExitFalls + 1);
    localparam logic [CntW-1:0]  CntMax  = '1;
    localparam logic [ExitW-1:0] ExitMax = ExitW'(HdrExitFalls);

    logic sda_stable_high, sda_stable_low;
    logic unused_sda_stable_low;

    bus_line_filter #(.CntW(CntW)) u_scl_filter (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .line_i        (scl_i),
        .t_r_i         (t_r_i),
        .t_f_i         (t_f_i),
        .posedge_o     (scl_posedge_o),
        .negedge_o     (scl_negedge_o),
        .stable_high_o (scl_stable_high_o),
        .stable_low_o  (scl_stable_low_o)
    );

    bus_line_filter #(.CntW(CntW)) u_sda_filter (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .line_i        (sda_i),
        .t_r_i         (t_r_i),
        .t_f_i         (t_f_i),
        .posedge_o     (sda_posedge_o),
        .negedge_o     (sda_negedge_o),
        .stable_high_o (sda_stable_high),
        .stable_low_o  (sda_stable_low)
    );

    assign unused_sda_stable_low = sda_stable_low;

    bus_state_e       state_q, state_d;
    logic             start_pend_q, start_pend_d;
    logic             stop_pend_q, stop_pend_d;
    logic             exit_armed_q, exit_armed_d;
    logic [ExitW-1:0] exit_cnt_q, exit_cnt_d;
    logic [CntW-1:0]  idle_cnt_q, idle_cnt_d;
    logic             sticky_q, sticky_d;

    logic start_trig, stop_trig, start_evt, stop_evt, exit_full;

    // Same-direction SCL edges disqualify the SDA edge as framing.
    assign start_trig = scl_stable_high_o && sda_negedge_o && !scl_negedge_o;
    assign stop_trig  = scl_stable_high_o && sda_posedge_o && !scl_posedge_o;
    assign start_evt  = enable_i && start_pend_q && scl_i;
    assign stop_evt   = enable_i && stop_pend_q && scl_i;
    assign exit_full  = (exit_cnt_q == ExitMax);

    always_comb begin
        state_d        = state_q;
        start_pend_d   = start_trig;
        stop_pend_d    = stop_trig;
        exit_armed_d   = 1'b0;
        exit_cnt_d     = '0;
        start_det_o    = 1'b0;
        rstart_det_o   = 1'b0;
        stop_det_o     = 1'b0;
        hdr_exit_det_o = 1'b0;

        unique case (state_q)
            BUS_FREE: begin
                if (start_evt) begin
                    start_det_o = 1'b1;
                    state_d     = BUS_ACTIVE;
                end
            end
            BUS_ACTIVE: begin
                if (stop_evt) begin
                    stop_det_o = 1'b1;
                    state_d    = BUS_FREE;
                end else if (start_evt) begin
                    rstart_det_o = 1'b1;
                end else if (is_in_hdr_mode_i) begin
                    state_d = BUS_HDR;
                end
            end
            BUS_HDR: begin
                exit_armed_d = exit_armed_q;
                exit_cnt_d   = exit_cnt_q;
                if (scl_stable_low_o && sda_stable_high) exit_armed_d = 1'b1;
                if (exit_armed_q && sda_negedge_o && !scl_i && !exit_full) begin
                    exit_cnt_d = exit_cnt_q + 1'b1;
                end
                // A completed pattern survives the SCL rise that precedes its STOP.
                if (scl_posedge_o && !exit_full) begin
                    exit_armed_d = 1'b0;
                    exit_cnt_d   = '0;
                end
                if (stop_evt && exit_full) begin
                    hdr_exit_det_o = 1'b1;
                    stop_det_o     = 1'b1;
                    state_d        = BUS_FREE;
                    exit_armed_d   = 1'b0;
                    exit_cnt_d     = '0;
                end
            end
            default: state_d = BUS_FREE;
        endcase

        if (state_q == BUS_FREE && scl_i && sda_i) begin
            idle_cnt_d = (idle_cnt_q == CntMax) ? idle_cnt_q : idle_cnt_q + 1'b1;
        end else begin
            idle_cnt_d = '0;
        end

        arb_lost_o = scl_posedge_o && sda_drive_en_i && sda_drive_i && !sda_i;
        sticky_d   = (stop_det_o || !enable_i) ? 1'b0 : (sticky_q || arb_lost_o);

        if (!enable_i) begin
            state_d      = BUS_FREE;
            start_pend_d = 1'b0;
            stop_pend_d  = 1'b0;
            exit_armed_d = 1'b0;
            exit_cnt_d   = '0;
            idle_cnt_d   = '0;
        end
    end

    always_comb begin
        bus_available_o   = enable_i && (state_q == BUS_FREE) && (idle_cnt_q != '0) &&
                            (idle_cnt_q >= t_avail_i);
        bus_idle_o        = enable_i && (state_q == BUS_FREE) && (idle_cnt_q != '0) &&
                            (idle_cnt_q >= t_idle_i);
        arb_lost_sticky_o = sticky_q;
        bus_state_o       = enable_i ? state_q : BUS_FREE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= BUS_FREE;
            start_pend_q <= 1'b0;
            stop_pend_q  <= 1'b0;
            exit_armed_q <= 1'b0;
            exit_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            sticky_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_pend_q <= start_pend_d;
            stop_pend_q  <= stop_pend_d;
            exit_armed_q <= exit_armed_d;
            exit_cnt_q   <= exit_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            sticky_q     <= sticky_d;
        end
    end

endmodule
